// File: rtl/s2p_frame_ctrl.sv
// Serial frame controller: start bit, WIDTH data bits, optional even parity, stop bit.
// Optional parity checking is enabled by defining S2P_PARITY_CHECK_EN.
module s2p_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serin,
    input  logic             dout_ready,
    input  logic             clr_err,
    output logic             load,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err,
    output logic             overrun
`ifdef S2P_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef S2P_PARITY_CHECK_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_frame_err;
    logic               r_overrun;
    logic               r_load;
    logic               r_busy;

    logic               w_stop_ok;
    logic               w_par_ok;
    logic               w_load_word;
    logic               w_overrun_evt;
    logic               w_frame_err_evt;
    logic               w_accept;

`ifdef S2P_PARITY_CHECK_EN
    logic               r_par_bit;
    logic               r_parity_err;

    function automatic logic even_parity_ok(input logic [WIDTH-1:0] data, input logic pbit);
        return ~((^data) ^ pbit);
    endfunction
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic bit_in);
        if (MSB_FIRST) begin
            return {cur[WIDTH-2:0], bit_in};
        end else begin
            return {bit_in, cur[WIDTH-1:1]};
        end
    endfunction

    // Next-state logic for the frame sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!serin) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_bit_cnt == LAST_CNT) begin
`ifdef S2P_PARITY_CHECK_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_STOP;
`endif
                end else begin
                    w_next_state = ST_DATA;
                end
            end
`ifdef S2P_PARITY_CHECK_EN
            ST_PARITY: w_next_state = ST_STOP;
`endif
            ST_STOP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Stop-bit outcome decode: load, overrun, framing error
    always_comb begin
        w_stop_ok = (r_state == ST_STOP) && serin;
`ifdef S2P_PARITY_CHECK_EN
        w_par_ok  = even_parity_ok(r_shreg, r_par_bit);
`else
        w_par_ok  = 1'b1;
`endif
        w_accept        = r_dout_valid && dout_ready;
        w_load_word     = w_stop_ok && w_par_ok && (!r_dout_valid || dout_ready);
        w_overrun_evt   = w_stop_ok && w_par_ok && r_dout_valid && !dout_ready;
        w_frame_err_evt = (r_state == ST_STOP) && !serin;
    end

    // State, counter, shifter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef S2P_PARITY_CHECK_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_load  <= (w_next_state == ST_DATA);
            r_busy  <= (w_next_state != ST_IDLE);

            if (r_state == ST_DATA) begin
                r_shreg <= shift_in(r_shreg, serin);
                if (r_bit_cnt != LAST_CNT) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end else begin
                    r_bit_cnt <= r_bit_cnt;
                end
            end else begin
                r_bit_cnt <= '0;
            end

`ifdef S2P_PARITY_CHECK_EN
            if (r_state == ST_PARITY) begin
                r_par_bit <= serin;
            end else begin
                r_par_bit <= r_par_bit;
            end
            r_parity_err <= w_stop_ok && !w_par_ok;
`endif

            // A good stop on the draining edge reloads instead of clearing
            if (w_load_word) begin
                r_dout       <= r_shreg;
                r_dout_valid <= 1'b1;
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= r_dout_valid;
            end

            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end

            r_frame_err <= w_frame_err_evt;
        end
    end

    assign load       = r_load;
    assign busy       = r_busy;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
`ifdef S2P_PARITY_CHECK_EN
    assign parity_err = r_parity_err;
`endif

endmodule
